// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage instruction fields and pipeline control bundle for hazard_scoreboard
interface hazard_scoreboard_if #(parameter int REG_AW = 5);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_we;
  logic [REG_AW-1:0] id_rd;
  logic [1:0]        id_class;
  logic              mem_stall;
  logic              branch_taken;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              stall;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_rd, id_class,
           mem_stall, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_we, id_rd, id_class,
           mem_stall, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, stall
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown hazard scoreboard for the 5-stage pipeline
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scoreboard_if.slave   bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  localparam int NREG = 1 << REG_AW;

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic             rs_pend;
  logic             rt_pend;
  logic             haz;
  logic             issue;
  logic [CNT_W-1:0] lat;

  // Register 0 is hard-wired zero, so it never reports a pending write.
  assign rs_pend = (bus.id_rs != '0) && (cnt[bus.id_rs] != '0);
  assign rt_pend = (bus.id_rt != '0) && (cnt[bus.id_rt] != '0);
  assign haz     = bus.id_valid && ((bus.id_use_rs && rs_pend) || (bus.id_use_rt && rt_pend));

  always_comb begin
    lat = '0;
    case (bus.id_class)
      2'b01:   lat = CNT_W'(LOAD_LAT);
      2'b10:   lat = CNT_W'(MUL_LAT);
      default: lat = '0;
    endcase
  end

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.stall       = 1'b0;
    issue           = 1'b0;
    if (bus.mem_stall) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
    end else if (bus.branch_taken) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (haz) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
      bus.stall       = 1'b1;
    end else begin
      issue = bus.id_valid && bus.id_we && (bus.id_rd != '0);
    end
  end

  // A new write never shortens an older, longer wait on the same register.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - 1'b1 : '0;
      if (issue && (bus.id_rd == REG_AW'(r)) && (lat > cnt_nxt[r]))
        cnt_nxt[r] = lat;
    end
    cnt_nxt[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
    end else if (!bus.mem_stall) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_nxt[r];
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.ifid_flush && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table-driven self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam logic [4:0] RUN = 5'b11000;
  localparam logic [4:0] HAZ = 5'b00011;
  localparam logic [4:0] FRZ = 5'b00000;
  localparam logic [4:0] BR  = 5'b11110;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       we;
    logic [4:0] rd;
    logic [1:0] cls;
    logic       ms;
    logic       br;
    logic [4:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   exp_stall_edges = 0;
  int   exp_flush_edges = 0;
  logic [4:0] exp_q [$];
  logic [4:0] last_exp;
  vec_t       vecs [$];

  hazard_scoreboard_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .MUL_LAT(3), .CNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                              input logic use_rs, input logic use_rt, input logic we,
                              input logic [4:0] rd, input logic [1:0] cls, input logic ms,
                              input logic br, input logic [4:0] exp);
    vec_t v;
    v.valid = valid; v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt;
    v.we = we; v.rd = rd; v.cls = cls; v.ms = ms; v.br = br; v.exp = exp;
    return v;
  endfunction

  function automatic logic [4:0] outs();
    return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.stall};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Drive one row, queue its expectation, compare at the falling edge.
  task automatic apply(input vec_t v, input int idx);
    logic [4:0] e;
    bus.id_valid = v.valid; bus.id_rs = v.rs; bus.id_rt = v.rt;
    bus.id_use_rs = v.use_rs; bus.id_use_rt = v.use_rt; bus.id_we = v.we;
    bus.id_rd = v.rd; bus.id_class = v.cls; bus.mem_stall = v.ms; bus.branch_taken = v.br;
    exp_q.push_back(v.exp);
    @(negedge clk);
    e = exp_q.pop_front();
    last_exp = e;
    check($sformatf("row%0d {pcw,ifidw,flush,bubble,stall}", idx), 32'(outs()), 32'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (last_exp[0]) exp_stall_edges++;
    if (last_exp[2]) exp_flush_edges++;
  endtask

  initial begin
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_we = 0; bus.id_rd = 0; bus.id_class = 0; bus.mem_stall = 0; bus.branch_taken = 0;

    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, RUN));
    vecs.push_back(mk(1, 8, 0, 1, 0, 1, 10, 0, 0, 0, HAZ));
    vecs.push_back(mk(1, 8, 0, 1, 0, 1, 10, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, RUN));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, HAZ));
    vecs.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, HAZ));
    vecs.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 1, 0, FRZ));
    vecs.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, HAZ));
    vecs.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, HAZ));
    vecs.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 2, 0, 0, RUN));
    vecs.push_back(mk(1, 7, 0, 1, 0, 1, 7, 2, 0, 1, BR));
    vecs.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, HAZ));
    vecs.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, HAZ));
    vecs.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 2, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, HAZ));
    vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, HAZ));
    vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 6, 3, 0, 0, RUN));
    vecs.push_back(mk(1, 6, 6, 1, 1, 0, 0, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 11, 2, 0, 0, RUN));
    vecs.push_back(mk(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, RUN));
    vecs.push_back(mk(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, HAZ));
    vecs.push_back(mk(0, 11, 0, 1, 0, 0, 0, 0, 0, 0, RUN));

    #2;
    check("reset outputs", 32'(outs()), 32'(RUN));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
      step();
    end

    // Asynchronous reset while cnt[4] is still pending.
    apply(mk(1, 0, 0, 0, 0, 1, 4, 2, 0, 0, RUN), 100);
    step();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN), 101);
    step();
    apply(mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, HAZ), 102);
`ifdef HAZARD_PERF_EN
    check("perf_stall_cnt before rst", perf_stall_cnt, 32'(exp_stall_edges));
    check("perf_flush_cnt before rst", perf_flush_cnt, 32'(exp_flush_edges));
`endif
    rst = 1'b1;
    #1;
    check("outputs during async rst", 32'(outs()), 32'(RUN));
`ifdef HAZARD_PERF_EN
    check("perf_stall_cnt cleared", perf_stall_cnt, 32'd0);
    check("perf_flush_cnt cleared", perf_flush_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_stall_edges = 0;
    exp_flush_edges = 0;
    apply(mk(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, RUN), 103);
    step();
`ifdef HAZARD_PERF_EN
    check("perf_stall_cnt after rst", perf_stall_cnt, 32'(exp_stall_edges));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
